// File: rtl/baud_tick_gen.sv
// Baud tick generator. Derives a receiver oversampling strobe, a transmitter
// bit strobe and a 50% duty baud square wave from the system clock. Seven
// preset rates are computed at elaboration; an eighth selection takes a
// run-time divisor. Any change of the effective divisor restarts all timing
// from zero so that no partial period at the old rate is ever emitted.
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [2:0]           baud_rate,
  input  logic [DIV_WIDTH-1:0] custom_div,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic                 baud_clk,
  output logic                 div_error
);

  localparam int unsigned OsW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsHalf = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] RateCustom = 3'b111;

  // Rounded clocks per sample period for a given baud rate.
  function automatic longint unsigned preset_div(input longint unsigned baud);
    longint unsigned per_bit;
    per_bit = baud * 64'(OVERSAMPLE);
    return (64'(CLK_FREQ) + per_bit / 2) / per_bit;
  endfunction

  // Entry 7 is the custom slot and is never read.
  localparam longint unsigned DivRaw [8] = '{
    preset_div(64'd2400),
    preset_div(64'd4800),
    preset_div(64'd9600),
    preset_div(64'd19200),
    preset_div(64'd38400),
    preset_div(64'd57600),
    preset_div(64'd115200),
    64'd0
  };

  if ((OVERSAMPLE < 2) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must be even and at least 2");
  end

  for (genvar i = 0; i < 7; i++) begin : g_preset_chk
    if (DivRaw[i] >= (64'd1 << DIV_WIDTH)) begin : g_bad_div
      $error("baud_tick_gen: preset divisor does not fit DIV_WIDTH");
    end
  end

  // Maps a rate select and custom divisor to the effective sample period.
  function automatic logic [DIV_WIDTH-1:0] decode_div(input logic [2:0]           rate,
                                                      input logic [DIV_WIDTH-1:0] cdiv);
    logic [DIV_WIDTH-1:0] d;
    if (rate == RateCustom) begin
      d = cdiv;
    end else begin
      d = DIV_WIDTH'(DivRaw[rate]);
    end
    return d;
  endfunction

  logic [2:0]           sel_rate_q;
  logic [DIV_WIDTH-1:0] sel_div_q;
  logic [DIV_WIDTH-1:0] div_prev_q;
  logic [DIV_WIDTH-1:0] sample_cnt_q;
  logic [OsW-1:0]       os_cnt_q;
  logic                 rx_tick_q;
  logic                 tx_tick_q;
  logic                 baud_clk_q;
  logic                 div_error_q;

  logic [DIV_WIDTH-1:0] div;
  logic                 div_bad;
  logic                 div_changed;
  logic                 sample_wrap;

  // Decode the active divisor and the per-cycle control conditions.
  always_comb begin
    div         = decode_div(sel_rate_q, sel_div_q);
    div_bad     = (div < DIV_WIDTH'(2));
    div_changed = (div != div_prev_q);
    sample_wrap = (sample_cnt_q == (div - DIV_WIDTH'(1)));
  end

  // Selection register plus last cycle's divisor for change detection. On
  // reset the previous divisor is loaded with the new one so that leaving
  // reset is not mistaken for a rate change.
  always_ff @(posedge clock) begin
    sel_rate_q <= baud_rate;
    sel_div_q  <= custom_div;
    if (!reset_n) begin
      div_prev_q <= decode_div(baud_rate, custom_div);
    end else begin
      div_prev_q <= div;
    end
  end

  // Sample and oversample counters with registered strobes and baud clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_cnt_q <= '0;
      os_cnt_q     <= '0;
      rx_tick_q    <= 1'b0;
      tx_tick_q    <= 1'b0;
      baud_clk_q   <= 1'b0;
      div_error_q  <= 1'b0;
    end else begin
      div_error_q <= div_bad;
      rx_tick_q   <= 1'b0;
      tx_tick_q   <= 1'b0;
      if (div_bad || div_changed) begin
        // Restart as if from reset; no tick in this cycle.
        sample_cnt_q <= '0;
        os_cnt_q     <= '0;
        baud_clk_q   <= 1'b0;
      end else if (enable) begin
        if (sample_wrap) begin
          sample_cnt_q <= '0;
          rx_tick_q    <= 1'b1;
          if (os_cnt_q == OsLast) begin
            os_cnt_q  <= '0;
            tx_tick_q <= 1'b1;
          end else begin
            os_cnt_q <= os_cnt_q + OsW'(1);
          end
          if ((os_cnt_q == OsHalf) || (os_cnt_q == OsLast)) begin
            baud_clk_q <= ~baud_clk_q;
          end
        end else begin
          sample_cnt_q <= sample_cnt_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  assign rx_tick   = rx_tick_q;
  assign tx_tick   = tx_tick_q;
  assign baud_clk  = baud_clk_q;
  assign div_error = div_error_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: two instances (OVERSAMPLE 4 and 16) share the
// inputs and are compared every cycle against an arithmetic model that tracks
// only the number of counting cycles since the last restart.
module tb_baud_tick_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  baud_rate;
  logic [15:0] custom_div;
  logic        rx_a, tx_a, bclk_a, err_a;
  logic        rx_b, tx_b, bclk_b, err_b;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  longint tcount = 0;
  longint cyc = 0;

  always #5 clock = ~clock;

  baud_tick_gen #(
    .CLK_FREQ  (50000000),
    .OVERSAMPLE(4),
    .DIV_WIDTH (16)
  ) u_dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .baud_rate (baud_rate),
    .custom_div(custom_div),
    .rx_tick   (rx_a),
    .tx_tick   (tx_a),
    .baud_clk  (bclk_a),
    .div_error (err_a)
  );

  baud_tick_gen #(
    .CLK_FREQ  (50000000),
    .OVERSAMPLE(16),
    .DIV_WIDTH (16)
  ) u_dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .baud_rate (baud_rate),
    .custom_div(custom_div),
    .rx_tick   (rx_b),
    .tx_tick   (tx_b),
    .baud_clk  (bclk_b),
    .div_error (err_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint os_of(input int i);
    return (i == 0) ? 64'd4 : 64'd16;
  endfunction

  function automatic longint div_of(input int i, input logic [2:0] rate,
                                    input logic [15:0] cdiv);
    longint baud;
    longint per;
    case (rate)
      3'd0:    baud = 2400;
      3'd1:    baud = 4800;
      3'd2:    baud = 9600;
      3'd3:    baud = 19200;
      3'd4:    baud = 38400;
      3'd5:    baud = 57600;
      3'd6:    baud = 115200;
      default: return longint'(cdiv);
    endcase
    per = baud * os_of(i);
    return (64'd50000000 + per / 2) / per;
  endfunction

  // Model state: n counts enabled cycles since the last restart.
  longint      m_prev [2];
  longint      m_n    [2];
  logic        m_rx   [2];
  logic        m_tx   [2];
  logic        m_bclk [2];
  logic        m_err  [2];
  logic [2:0]  m_rate;
  logic [15:0] m_cdiv;

  initial begin : model
    longint d;
    forever begin
      @(posedge clock);
      tcount++;
      if (!reset_n) begin
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
          m_prev[i] = div_of(i, baud_rate, custom_div);
          m_n[i]    = 0;
          m_rx[i]   = 1'b0;
          m_tx[i]   = 1'b0;
          m_bclk[i] = 1'b0;
          m_err[i]  = 1'b0;
        end
      end else begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          d = div_of(i, m_rate, m_cdiv);
          m_err[i] = (d < 2);
          m_rx[i]  = 1'b0;
          m_tx[i]  = 1'b0;
          if (d < 2 || d != m_prev[i]) begin
            m_n[i] = 0;
          end else if (enable) begin
            m_n[i]++;
            m_rx[i] = (m_n[i] % d == 0);
            m_tx[i] = (m_n[i] % (d * os_of(i)) == 0);
          end
          if (d >= 2) m_bclk[i] = ((m_n[i] / (d * os_of(i) / 2)) % 2) == 1;
          else        m_bclk[i] = 1'b0;
          m_prev[i] = d;
        end
      end
      m_rate = baud_rate;
      m_cdiv = custom_div;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      if (check_en) begin
        chk("rx_a",   longint'(rx_a),   longint'(m_rx[0]));
        chk("tx_a",   longint'(tx_a),   longint'(m_tx[0]));
        chk("bclk_a", longint'(bclk_a), longint'(m_bclk[0]));
        chk("err_a",  longint'(err_a),  longint'(m_err[0]));
        chk("rx_b",   longint'(rx_b),   longint'(m_rx[1]));
        chk("tx_b",   longint'(tx_b),   longint'(m_tx[1]));
        chk("bclk_b", longint'(bclk_b), longint'(m_bclk[1]));
        chk("err_b",  longint'(err_b),  longint'(m_err[1]));
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic at_cycle(input longint k);
    while (cyc < k) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic pulse_of(input int sel);
    case (sel)
      0:       return rx_a;
      1:       return tx_a;
      2:       return rx_b;
      default: return tx_b;
    endcase
  endfunction

  task automatic wait_pulse(input string name, input int sel, input int limit,
                            output longint t);
    int n;
    n = 0;
    t = -1;
    while (n < limit) begin
      @(negedge clock);
      n++;
      if (pulse_of(sel)) begin
        t = tcount;
        break;
      end
    end
    if (t < 0) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Literal timeline for custom_div=5, OVERSAMPLE=4 right after reset.
  task automatic pinned_custom5();
    at_cycle(0);
    chk("p_rst_rx",   longint'(rx_a),   64'd0);
    chk("p_rst_tx",   longint'(tx_a),   64'd0);
    chk("p_rst_bclk", longint'(bclk_a), 64'd0);
    chk("p_rst_err",  longint'(err_a),  64'd0);
    at_cycle(4);
    chk("p_rx_c4", longint'(rx_a), 64'd0);
    at_cycle(5);
    chk("p_rx_c5", longint'(rx_a), 64'd1);
    at_cycle(10);
    chk("p_rx_c10",   longint'(rx_a),   64'd1);
    chk("p_bclk_c10", longint'(bclk_a), 64'd1);
    at_cycle(19);
    chk("p_tx_c19",   longint'(tx_a),   64'd0);
    chk("p_bclk_c19", longint'(bclk_a), 64'd1);
    at_cycle(20);
    chk("p_tx_c20",   longint'(tx_a),   64'd1);
    chk("p_rx_c20",   longint'(rx_a),   64'd1);
    chk("p_bclk_c20", longint'(bclk_a), 64'd0);
  endtask

  initial begin : stimulus
    longint t0, t1, t2, t3, t4;
    int n_ticks;
    reset_n    = 1'b0;
    enable     = 1'b1;
    baud_rate  = 3'd7;
    custom_div = 16'd5;
    repeat (2) @(negedge clock);
    check_en = 1'b1;
    reset_n  = 1'b1;
    pinned_custom5();

    // Reset mid-operation while baud_clk is high and two samples are counted.
    do_reset();
    at_cycle(12);
    chk("mid_pre_bclk", longint'(bclk_a), 64'd1);
    do_reset();
    pinned_custom5();

    // Enable gap of 7 cycles starting at cycle 12.
    do_reset();
    at_cycle(12);
    enable = 1'b0;
    at_cycle(15);
    chk("en_rx_c15", longint'(rx_a), 64'd0);
    at_cycle(17);
    chk("en_bclk_c17", longint'(bclk_a), 64'd1);
    at_cycle(19);
    enable = 1'b1;
    at_cycle(21);
    chk("en_rx_c21", longint'(rx_a), 64'd0);
    at_cycle(22);
    chk("en_rx_c22", longint'(rx_a), 64'd1);

    // Rate change custom -> 115200 mid-period.
    do_reset();
    at_cycle(12);
    baud_rate = 3'd6;
    t0 = tcount;
    @(negedge clock);
    chk("rc_bclk_hold", longint'(bclk_a), 64'd1);
    @(negedge clock);
    chk("rc_bclk_clr", longint'(bclk_a), 64'd0);
    wait_pulse("rc_rx1", 2, 100, t1);
    chk("rc_first_rx", t1 - t0, 64'd29);
    wait_pulse("rc_rx2", 2, 100, t2);
    chk("p115200_rx_period", t2 - t1, 64'd27);
    wait_pulse("rc_tx1", 3, 1000, t3);
    chk("rc_first_tx", t3 - t0, 64'd434);
    wait_pulse("rc_tx2", 3, 1000, t4);
    chk("p115200_tx_period", t4 - t3, 64'd432);

    // 9600 preset periods.
    baud_rate = 3'd2;
    repeat (5) @(negedge clock);
    wait_pulse("p9600_rx1", 2, 1000, t1);
    wait_pulse("p9600_rx2", 2, 1000, t2);
    chk("p9600_rx_period", t2 - t1, 64'd326);
    wait_pulse("p9600_tx1", 3, 6000, t3);
    wait_pulse("p9600_tx2", 3, 6000, t4);
    chk("p9600_tx_period", t4 - t3, 64'd5216);

    // Divisor error and recovery.
    baud_rate  = 3'd7;
    custom_div = 16'd1;
    repeat (3) @(negedge clock);
    chk("de_err_a", longint'(err_a), 64'd1);
    chk("de_err_b", longint'(err_b), 64'd1);
    n_ticks = 0;
    repeat (100) begin
      @(negedge clock);
      if (rx_a | tx_a | bclk_a | rx_b | tx_b | bclk_b) n_ticks++;
    end
    chk("de_quiet", longint'(n_ticks), 64'd0);
    custom_div = 16'd3;
    repeat (3) @(negedge clock);
    chk("de_clear_a", longint'(err_a), 64'd0);
    wait_pulse("de_rx1", 0, 20, t1);
    wait_pulse("de_rx2", 0, 20, t2);
    chk("de_rx_period", t2 - t1, 64'd3);

    // Randomised traffic, checked every cycle by the model.
    repeat (4000) begin
      @(negedge clock);
      reset_n = ($urandom_range(0, 399) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) baud_rate = 3'($urandom_range(0, 5));
        else                           baud_rate = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7;
      end
      if ($urandom_range(0, 19) == 0) custom_div = 16'($urandom_range(0, 9));
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the UART baud clock divider.
- Generates three outputs from the system clock:
  - rx_tick: a one-cycle oversampling strobe for the receiver.
  - tx_tick: a one-cycle bit strobe for the transmitter.
  - baud_clk: a square wave at the baud rate.
- Supports 7 preset rates plus a run-time custom divisor, an enable, and clean restart on rate change.
- Sits between the system clock and the UART Tx/Rx units.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz; used to compute preset divisors at elaboration.
- OVERSAMPLE, 16: rx_tick pulses per bit period. Must be even and >= 2.
- DIV_WIDTH, 16: width of the sample counter and of custom_div.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = count; 0 = freeze counters and suppress ticks.
- baud_rate  in  3  rate select: 000=2400, 001=4800, 010=9600, 011=19200, 100=38400, 101=57600, 110=115200, 111=custom.
- custom_div  in  DIV_WIDTH  sample period in clocks; used only when baud_rate=111.
- rx_tick  out  1  one-cycle pulse every div clocks.
- tx_tick  out  1  one-cycle pulse every OVERSAMPLE rx_ticks.
- baud_clk  out  1  square wave, period OVERSAMPLE*div clocks.
- div_error  out  1  high while the selected divisor is < 2.

Behaviour:
- Preset divisor:
  - div = (CLK_FREQ + B*OVERSAMPLE/2) / (B*OVERSAMPLE), integer rounding, computed at elaboration.
  - Defaults: 9600 -> 326; 115200 -> 27.
  - Presets that do not fit DIV_WIDTH are an elaboration error.
- Selection register:
  - {baud_rate, custom_div} is registered every cycle into sel_q.
  - The active divisor div is decoded from sel_q, so a select change takes effect 1 cycle after the input changes.
- Reset (reset_n=0 at a clock edge):
  - sample_cnt=0, os_cnt=0.
  - rx_tick=0, tx_tick=0, baud_clk=0, div_error=0.
  - sel_q loads the current inputs.
  - Reset has priority over every other event.
- Sample counter:
  - Counts 0..div-1 while enabled.
  - At an edge where sample_cnt==div-1: sample_cnt wraps to 0 and rx_tick=1 for the following cycle. Otherwise rx_tick=0.
  - After reset release with enable=1, the first rx_tick is high in the cycle after the div-th edge.
- Oversample counter:
  - Increments on each rx_tick event; range 0..OVERSAMPLE-1.
  - At the event where os_cnt==OVERSAMPLE-1: os_cnt wraps to 0 and tx_tick=1 coincident with that rx_tick.
  - baud_clk toggles on the events where os_cnt==OVERSAMPLE/2-1 and os_cnt==OVERSAMPLE-1, giving a 50% duty cycle.
- Enable:
  - enable=0: counters and baud_clk hold their values; rx_tick and tx_tick are 0.
  - Resuming continues from the held counts; no phase loss.
- Rate change:
  - When the decoded div differs from the previous cycle's div, that cycle clears sample_cnt and os_cnt and forces baud_clk=0.
  - No tick is issued in that cycle.
  - Counting restarts as if from reset; no partial period is emitted at the old rate.
  - A change to custom_div while baud_rate != 111 is ignored.
- Divisor error:
  - If div < 2 (custom mode with custom_div of 0 or 1): div_error=1, counters held at 0, ticks=0, baud_clk=0.
  - Normal operation resumes per the rate-change rule once div >= 2.
- Outputs: all are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Custom divisor: OVERSAMPLE=4, baud_rate=111, custom_div=5, enable=1, release reset at cycle 0.
  - rx_tick high at cycles 5, 10, 15, 20, ...
  - tx_tick high at cycle 20, then every 20 cycles.
  - baud_clk rises at cycle 10, falls at 20; period 20 clocks.
- Default parameters: baud_rate=010 -> rx_tick period 326 clocks, tx_tick period 5216 clocks. baud_rate=110 -> rx_tick period 27, tx_tick period 432.
- Enable gating: with the custom_div=5 setup, drop enable for 7 cycles at cycle 12.
  - No ticks during the gap.
  - The next rx_tick arrives at cycle 22 (phase preserved).
  - baud_clk is held during the gap.
- Rate change: switch baud_rate 111 -> 110 mid-period.
  - Counters clear 1 cycle after the change and baud_clk drops to 0.
  - The first new rx_tick comes 27 clocks after the clear.
  - No runt tx_tick is issued.
- Divisor error: custom_div=1 -> div_error=1 and no ticks for 100 cycles. Then set custom_div=3 -> div_error=0 and rx_tick every 3 clocks.
- Reset mid-operation: assert reset_n=0 for 1 cycle while baud_clk=1 and os_cnt=2.
  - All outputs are 0 next cycle.
  - The tick sequence restarts exactly as in the first scenario.
